// File: rtl/genius_vga_seq_tx.sv
// Genius sprite-interface transmitter: plays latched colour sequences as timed
// VGA_FLAG pulses, echoes single presses and shows timed lose/win indications.
module genius_vga_seq_tx #(
  parameter int ON_CYCLES  = 25000000,
  parameter int OFF_CYCLES = 12500000,
  parameter int END_CYCLES = 100000000,
  parameter int MAX_LEN    = 16
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 START,
  input  logic [4:0]           LEN,
  input  logic [2*MAX_LEN-1:0] SEQ,
  input  logic                 ECHO_REQ,
  input  logic [1:0]           ECHO_COLOR,
  input  logic                 LOSE_REQ,
  input  logic                 WIN_REQ,
  output logic                 VGA_FLAG,
  output logic [1:0]           VGA,
  output logic                 VGA_LOSE,
  output logic                 VGA_WIN,
  output logic                 BUSY,
  output logic                 DONE,
  output logic [2:0]           dbg_state
);

  localparam int MAX_ON_OFF = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int MAX_CYC    = (MAX_ON_OFF > END_CYCLES) ? MAX_ON_OFF : END_CYCLES;
  localparam int CW         = $clog2(MAX_CYC) + 1;
  localparam int LW         = $clog2(MAX_LEN + 1);

  localparam logic [CW-1:0] ON_LD  = CW'(ON_CYCLES - 1);
  localparam logic [CW-1:0] OFF_LD = CW'(OFF_CYCLES - 1);
  localparam logic [CW-1:0] END_LD = CW'(END_CYCLES - 1);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] SHOW_ON   = 3'd1;
  localparam logic [2:0] SHOW_GAP  = 3'd2;
  localparam logic [2:0] LOSE_HOLD = 3'd3;
  localparam logic [2:0] WIN_HOLD  = 3'd4;
  localparam logic [2:0] END_GAP   = 3'd5;

  logic [2:0]           state;
  logic [CW-1:0]        cnt;
  logic [LW-1:0]        idx;
  logic [LW-1:0]        len_q;
  logic [2*MAX_LEN-1:0] seq_q;
  logic [LW-1:0]        len_clamp;
  logic [LW-1:0]        nxt_idx;
  logic [1:0]           nxt_color;
  logic                 lose_ok;

  // Requests are single-cycle strobes with no ready: a request is taken only
  // on the edge where the current state can accept it, otherwise it is dropped.
  assign len_clamp = (int'(LEN) > MAX_LEN) ? LW'(MAX_LEN) : LW'(LEN);
  assign nxt_idx   = idx + LW'(1);
  assign nxt_color = seq_q[{nxt_idx, 1'b0} +: 2];
  assign lose_ok   = LOSE_REQ && (state == IDLE || state == SHOW_ON || state == SHOW_GAP);
  assign dbg_state = state;

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state    <= IDLE;
      cnt      <= '0;
      idx      <= '0;
      len_q    <= '0;
      seq_q    <= '0;
      VGA_FLAG <= 1'b0;
      VGA      <= 2'b00;
      VGA_LOSE <= 1'b0;
      VGA_WIN  <= 1'b0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
    end else begin
      DONE <= 1'b0;
      if (lose_ok) begin
        state    <= LOSE_HOLD;
        VGA_FLAG <= 1'b0;
        VGA_LOSE <= 1'b1;
        BUSY     <= 1'b1;
        cnt      <= END_LD;
      end else begin
        case (state)
          IDLE: begin
            if (WIN_REQ) begin
              state   <= WIN_HOLD;
              VGA_WIN <= 1'b1;
              BUSY    <= 1'b1;
              cnt     <= END_LD;
            end else if (START) begin
              seq_q <= SEQ;
              len_q <= len_clamp;
              idx   <= '0;
              if (len_clamp == '0) begin
                DONE <= 1'b1;
              end else begin
                state    <= SHOW_ON;
                VGA_FLAG <= 1'b1;
                VGA      <= SEQ[1:0];
                BUSY     <= 1'b1;
                cnt      <= ON_LD;
              end
            end else if (ECHO_REQ) begin
              // An echo is just a one-element sequence.
              seq_q    <= {{(2*MAX_LEN-2){1'b0}}, ECHO_COLOR};
              len_q    <= LW'(1);
              idx      <= '0;
              state    <= SHOW_ON;
              VGA_FLAG <= 1'b1;
              VGA      <= ECHO_COLOR;
              BUSY     <= 1'b1;
              cnt      <= ON_LD;
            end
          end
          SHOW_ON: begin
            if (cnt == '0) begin
              state    <= SHOW_GAP;
              VGA_FLAG <= 1'b0;
              cnt      <= OFF_LD;
            end else begin
              cnt <= cnt - CW'(1);
            end
          end
          SHOW_GAP: begin
            if (cnt == '0) begin
              if (nxt_idx < len_q) begin
                idx      <= nxt_idx;
                state    <= SHOW_ON;
                VGA_FLAG <= 1'b1;
                VGA      <= nxt_color;
                cnt      <= ON_LD;
              end else begin
                state <= IDLE;
                DONE  <= 1'b1;
                BUSY  <= 1'b0;
              end
            end else begin
              cnt <= cnt - CW'(1);
            end
          end
          LOSE_HOLD, WIN_HOLD: begin
            if (cnt == '0) begin
              state    <= END_GAP;
              VGA_LOSE <= 1'b0;
              VGA_WIN  <= 1'b0;
              cnt      <= OFF_LD;
            end else begin
              cnt <= cnt - CW'(1);
            end
          end
          END_GAP: begin
            if (cnt == '0) begin
              state <= IDLE;
              DONE  <= 1'b1;
              BUSY  <= 1'b0;
            end else begin
              cnt <= cnt - CW'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_genius_vga_seq_tx.sv
// Directed bench for genius_vga_seq_tx: per-cycle expected output vectors are
// queued with each stimulus step and compared one cycle at a time.
module tb_genius_vga_seq_tx;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [4:0]  len;
  logic [31:0] seq;
  logic        echo_req;
  logic [1:0]  echo_color;
  logic        lose_req;
  logic        win_req;
  logic        vga_flag;
  logic [1:0]  vga;
  logic        vga_lose;
  logic        vga_win;
  logic        busy;
  logic        done;
  logic [2:0]  dbg_state;

  // Vector layout: {flag, vga[1:0], lose, win, busy, done}
  logic [6:0] exp_q[$];
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  genius_vga_seq_tx #(
    .ON_CYCLES(4), .OFF_CYCLES(2), .END_CYCLES(6), .MAX_LEN(16)
  ) dut (
    .CLK(clk), .RESET(reset_n), .START(start), .LEN(len), .SEQ(seq),
    .ECHO_REQ(echo_req), .ECHO_COLOR(echo_color), .LOSE_REQ(lose_req),
    .WIN_REQ(win_req), .VGA_FLAG(vga_flag), .VGA(vga), .VGA_LOSE(vga_lose),
    .VGA_WIN(vga_win), .BUSY(busy), .DONE(done), .dbg_state(dbg_state)
  );

  task automatic push(input logic f, input logic [1:0] v, input logic l,
                      input logic w, input logic b, input logic d, input int n);
    repeat (n) exp_q.push_back({f, v, l, w, b, d});
  endtask

  task automatic step(input string tag);
    logic [6:0] obs;
    logic [6:0] exp;
    @(posedge clk);
    #1;
    obs = {vga_flag, vga, vga_lose, vga_win, busy, done};
    vectors++;
    assert ($countones({vga_flag, vga_lose, vga_win}) <= 1) else begin
      miscompares++;
      $error("FAIL %s_exclusive observed=%b expected at most one of flag/lose/win", tag, {vga_flag, vga_lose, vga_win});
    end
    vectors++;
    if (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      assert (obs === exp) else begin
        miscompares++;
        $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
    end else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=<no entry queued>", tag, obs);
    end
  endtask

  task automatic drain(input string tag);
    while (exp_q.size() > 0) step(tag);
  endtask

  task automatic clear_reqs();
    start = 1'b0; echo_req = 1'b0; lose_req = 1'b0; win_req = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0; len = '0; seq = '0; echo_color = '0;
    clear_reqs();

    // 1. reset with random requests, then a single green colour
    push(0, 2'b00, 0, 0, 0, 0, 3);
    repeat (3) begin
      start = 1'($urandom_range(0, 1)); echo_req = 1'($urandom_range(0, 1));
      lose_req = 1'($urandom_range(0, 1)); win_req = 1'($urandom_range(0, 1));
      len = 5'($urandom_range(0, 31)); seq = $urandom;
      step("reset");
    end
    reset_n = 1'b1; clear_reqs();
    push(0, 2'b00, 0, 0, 0, 0, 1);
    step("idle_after_reset");
    len = 5'd1; seq = 32'h0000_0001;
    push(1, 2'b01, 0, 0, 1, 0, 4);
    push(0, 2'b01, 0, 0, 1, 0, 2);
    push(0, 2'b01, 0, 0, 0, 1, 1);
    push(0, 2'b01, 0, 0, 0, 0, 1);
    start = 1'b1; step("len1");
    start = 1'b0; drain("len1");

    // 2. BLUE, RED, RED; input changes and requests mid-playback are ignored
    len = 5'd3; seq = 32'h0000_0028;
    push(1, 2'b00, 0, 0, 1, 0, 4); push(0, 2'b00, 0, 0, 1, 0, 2);
    push(1, 2'b10, 0, 0, 1, 0, 4); push(0, 2'b10, 0, 0, 1, 0, 2);
    push(1, 2'b10, 0, 0, 1, 0, 4); push(0, 2'b10, 0, 0, 1, 0, 2);
    push(0, 2'b10, 0, 0, 0, 1, 1);
    push(0, 2'b10, 0, 0, 0, 0, 1);
    start = 1'b1; step("seq3");
    start = 1'b0;
    seq = $urandom; len = 5'd5; start = 1'b1; echo_req = 1'b1; echo_color = 2'b11;
    step("seq3_busy_reqs");
    clear_reqs(); drain("seq3");

    // 3. LEN=0 finishes at once; LEN=20 clamps to 16 pulses
    len = 5'd0;
    push(0, 2'b10, 0, 0, 0, 1, 1);
    push(0, 2'b10, 0, 0, 0, 0, 2);
    start = 1'b1; step("len0");
    start = 1'b0; drain("len0");
    len = 5'd20; seq = 32'hFFFF_FFFF;
    for (int i = 0; i < 16; i++) begin
      push(1, 2'b11, 0, 0, 1, 0, 4);
      push(0, 2'b11, 0, 0, 1, 0, 2);
    end
    push(0, 2'b11, 0, 0, 0, 1, 1);
    push(0, 2'b11, 0, 0, 0, 0, 2);
    start = 1'b1; step("len20");
    start = 1'b0; drain("len20");

    // 4. LOSE on the 2nd cycle of element 1
    len = 5'd3; seq = 32'h0000_0039;
    push(1, 2'b01, 0, 0, 1, 0, 4); push(0, 2'b01, 0, 0, 1, 0, 2);
    push(1, 2'b10, 0, 0, 1, 0, 2);
    push(0, 2'b10, 1, 0, 1, 0, 6);
    push(0, 2'b10, 0, 0, 1, 0, 2);
    push(0, 2'b10, 0, 0, 0, 1, 1);
    push(0, 2'b10, 0, 0, 0, 0, 2);
    start = 1'b1; step("lose_play");
    start = 1'b0;
    repeat (7) step("lose_play");
    lose_req = 1'b1; step("lose_hold");
    lose_req = 1'b0; drain("lose");

    // 5. WIN beats START and ECHO; WIN during playback is ignored
    len = 5'd2; seq = 32'h0000_0005; echo_color = 2'b01;
    push(0, 2'b10, 0, 1, 1, 0, 6);
    push(0, 2'b10, 0, 0, 1, 0, 2);
    push(0, 2'b10, 0, 0, 0, 1, 1);
    push(0, 2'b10, 0, 0, 0, 0, 1);
    win_req = 1'b1; start = 1'b1; echo_req = 1'b1; step("win_prio");
    clear_reqs(); drain("win");
    len = 5'd1; seq = 32'h0000_0000;
    push(1, 2'b00, 0, 0, 1, 0, 4); push(0, 2'b00, 0, 0, 1, 0, 2);
    push(0, 2'b00, 0, 0, 0, 1, 1);
    push(0, 2'b00, 0, 0, 0, 0, 1);
    start = 1'b1; step("win_ignored");
    start = 1'b0; step("win_ignored");
    win_req = 1'b1; step("win_ignored");
    win_req = 1'b0; drain("win_ignored");

    // 6. reset mid-SHOW_ON aborts without DONE; then a yellow echo
    len = 5'd2; seq = 32'h0000_0009;
    push(1, 2'b01, 0, 0, 1, 0, 3);
    push(0, 2'b00, 0, 0, 0, 0, 3);
    start = 1'b1; step("abort_play");
    start = 1'b0; step("abort_play"); step("abort_play");
    reset_n = 1'b0; step("abort_reset");
    reset_n = 1'b1; drain("abort_after");
    echo_color = 2'b11;
    push(1, 2'b11, 0, 0, 1, 0, 4); push(0, 2'b11, 0, 0, 1, 0, 2);
    push(0, 2'b11, 0, 0, 0, 1, 1);
    push(0, 2'b11, 0, 0, 0, 0, 1);
    echo_req = 1'b1; step("echo");
    echo_req = 1'b0; drain("echo");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
